// File: rtl/vga_scan_reader_if.sv
// rtl/vga_scan_reader_if.sv - video-memory read port between scan reader and frame store
interface vga_scan_reader_if;
    logic [15:0] oReadAddress;
    logic [2:0]  iReadData;

    modport master (output oReadAddress, input  iReadData);
    modport slave  (input  oReadAddress, output iReadData);
endinterface

// File: rtl/vga_scan_reader.sv
// rtl/vga_scan_reader.sv - 640x480 VGA scan generator showing a 256x256 image window from video memory
module vga_scan_reader #(
    parameter int         IMG_X0       = 192,
    parameter int         IMG_Y0       = 112,
    parameter logic [2:0] BORDER_RGB   = 3'b000,
    parameter int         H_ACTIVE     = 640,
    parameter int         H_SYNC_START = 656,
    parameter int         H_SYNC_END   = 751,
    parameter int         H_TOTAL      = 800,
    parameter int         V_ACTIVE     = 480,
    parameter int         V_SYNC_START = 490,
    parameter int         V_SYNC_END   = 491,
    parameter int         V_TOTAL      = 525
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iEnable,
    vga_scan_reader_if.master mem,
    output logic [2:0]        oVGA_RGB,
    output logic              oHsync,
    output logic              oVsync,
    output logic [9:0]        oHcounter,
    output logic [9:0]        oVcounter,
    output logic              oFrameStart
);
    localparam logic [9:0] X_FIRST = 10'(IMG_X0);
    localparam logic [9:0] X_LAST  = 10'(IMG_X0 + 255);
    localparam logic [9:0] Y_FIRST = 10'(IMG_Y0);
    localparam logic [9:0] Y_LAST  = 10'(IMG_Y0 + 255);
    localparam logic [7:0] X_LOW   = 8'(IMG_X0);
    localparam logic [7:0] Y_LOW   = 8'(IMG_Y0);

    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       h_last;
    logic       v_last;
    logic       in_active;
    logic       in_window;
    logic [7:0] col;
    logic [7:0] row;

    assign h_last    = (h == 10'(H_TOTAL - 1));
    assign v_last    = (v == 10'(V_TOTAL - 1));
    assign in_active = (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
    assign in_window = (h >= X_FIRST) && (h <= X_LAST) && (v >= Y_FIRST) && (v <= Y_LAST);

    // only the low byte of the offset matters, so subtract on 8 bits
    assign col = h[7:0] - X_LOW;
    assign row = v[7:0] - Y_LOW;

    // address depends only on the registered counters, so it is stable through the pe=0 clock
    assign mem.oReadAddress = in_window ? {col, row} : 16'h0000;

    assign oHcounter = h;
    assign oVcounter = v;

    // pixel enable: high on every second clock
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) pe <= 1'b0;
        else        pe <= ~pe;
    end

    // raster counters advance once per pixel
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            h <= '0;
            v <= '0;
        end else if (pe) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // output registers capture the current pixel before the counters move on
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oVGA_RGB <= 3'b000;
            oHsync   <= 1'b1;
            oVsync   <= 1'b1;
        end else if (pe) begin
            if (in_active && iEnable) oVGA_RGB <= in_window ? mem.iReadData : BORDER_RGB;
            else                      oVGA_RGB <= 3'b000;
            oHsync <= !((h >= 10'(H_SYNC_START)) && (h <= 10'(H_SYNC_END)));
            oVsync <= !((v >= 10'(V_SYNC_START)) && (v <= 10'(V_SYNC_END)));
        end
    end

    // one-clock pulse after the pixel at the frame origin is loaded
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) oFrameStart <= 1'b0;
        else        oFrameStart <= pe && (h == 10'd0) && (v == 10'd0);
    end
endmodule
